// File: rtl/fb_wr_arbiter.sv
// Frame-buffer RAM write-port arbiter: merges buffered 8080 MCU writes with a
// constant-word fill engine onto one registered write port, with bounded MCU bursts.
module fb_wr_arbiter #(
    parameter  int COL_NUM_LOG2    = 8,
    parameter  int FIFO_DEPTH_LOG2 = 2,
    parameter  int MCU_BURST       = 4,
    localparam int AW              = COL_NUM_LOG2 + 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mcu_wr,
    input  logic [AW-1:0] mcu_addr,
    input  logic [31:0]   mcu_data,
    input  logic          fill_start,
    input  logic [31:0]   fill_data,
    input  logic          ram_ready,
    input  logic          ovf_clr,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_data,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          ovf
);

    // Write handshake: ram_ready high in a cycle means a write granted in that
    // cycle may be issued; it appears as a one-cycle ram_wr on the next edge and
    // the RAM side must take every ram_wr pulse without further backpressure.

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2+1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = (FIFO_DEPTH_LOG2)'(1);
    localparam logic [AW-1:0]              ADDR_ONE = AW'(1);
    localparam logic [2:0]                 BURST_LIM = 3'(MCU_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]              fifo_addr [DEPTH];
    logic [31:0]                fifo_data [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic [2:0]                 burst_cnt;
    logic [AW-1:0]              fill_addr;
    logic [31:0]                fill_word;

    logic fifo_empty, fifo_full, fill_last;
    logic grant_mcu, grant_fill, push, drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign fill_last  = (fill_addr == '1);
    assign fill_busy  = (state == FILL);

    // MCU wins unless it has used up its burst allowance while a fill waits.
    always_comb begin
        grant_mcu  = 1'b0;
        grant_fill = 1'b0;
        if (ram_ready) begin
            if (!fifo_empty && !(state == FILL && burst_cnt == BURST_LIM)) begin
                grant_mcu = 1'b1;
            end else if (state == FILL) begin
                grant_fill = 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push = mcu_wr && (!fifo_full || grant_mcu);
    assign drop = mcu_wr && fifo_full && !grant_mcu;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_start) state_nxt = FILL;
            FILL:    if (grant_fill && fill_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mcu_addr;
            fifo_data[wr_ptr] <= mcu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + PTR_ONE;
            if (grant_mcu) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, grant_mcu})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // fill_start during an active fill is ignored, data included.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_addr <= '0;
            fill_word <= '0;
        end else if (state == IDLE && fill_start) begin
            fill_addr <= '0;
            fill_word <= fill_data;
        end else if (grant_fill) begin
            fill_addr <= fill_addr + ADDR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            burst_cnt <= '0;
        end else if (grant_fill) begin
            burst_cnt <= '0;
        end else if (grant_mcu && burst_cnt != 3'b111) begin
            burst_cnt <= burst_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            fill_done <= 1'b0;
        end else begin
            ram_wr    <= grant_mcu || grant_fill;
            fill_done <= grant_fill && fill_last;
            if (grant_mcu) begin
                ram_addr <= fifo_addr[rd_ptr];
                ram_data <= fifo_data[rd_ptr];
            end else if (grant_fill) begin
                ram_addr <= fill_addr;
                ram_data <= fill_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Directed bench for fb_wr_arbiter (AW=6, 4-entry FIFO, burst 4) with a write
// scoreboard holding {fill_done, addr, data} in expected order.
module tb_fb_wr_arbiter;

    localparam int AW = 6;
    localparam int W  = 1 + AW + 32;

    logic          clk;
    logic          rst;
    logic          mcu_wr;
    logic [AW-1:0] mcu_addr;
    logic [31:0]   mcu_data;
    logic          fill_start;
    logic [31:0]   fill_data;
    logic          ram_ready;
    logic          ovf_clr;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          fill_busy;
    logic          fill_done;
    logic          ovf;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    bit mon_en = 1'b0;

    fb_wr_arbiter #(
        .COL_NUM_LOG2(1),
        .FIFO_DEPTH_LOG2(2),
        .MCU_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mcu_wr(mcu_wr),
        .mcu_addr(mcu_addr),
        .mcu_data(mcu_data),
        .fill_start(fill_start),
        .fill_data(fill_data),
        .ram_ready(ram_ready),
        .ovf_clr(ovf_clr),
        .ram_wr(ram_wr),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .fill_busy(fill_busy),
        .fill_done(fill_done),
        .ovf(ovf)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ent(input bit done, input logic [AW-1:0] a,
                                         input logic [31:0] d);
        return {done, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic exp_fill(input logic [31:0] d);
        for (int i = 0; i < 64; i++) exp_q.push_back(ent(i == 63, AW'(i), d));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_wr"},    ram_wr,    0);
        chk({tag, "_ram_addr"},  ram_addr,  0);
        chk({tag, "_ram_data"},  ram_data,  0);
        chk({tag, "_fill_busy"}, fill_busy, 0);
        chk({tag, "_fill_done"}, fill_done, 0);
        chk({tag, "_ovf"},       ovf,       0);
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_wr) begin
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("write_word", {fill_done, ram_addr, ram_data}, exp_q.pop_front());
            end else begin
                chk("done_without_write", fill_done, 0);
            end
        end
    end

    initial begin
        int busy_cnt;
        int mi;
        int fa;

        rst = 1'b1; mcu_wr = 1'b0; mcu_addr = '0; mcu_data = '0;
        fill_start = 1'b0; fill_data = '0; ram_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        ram_ready = 1'b1;
        mon_en = 1'b1;
        repeat (2) tick();

        // MCU latency: strobe in cycle N, write visible in N+2 only
        exp_q.push_back(ent(0, 6'h25, 32'hDEADBEEF));
        mcu_wr = 1'b1; mcu_addr = 6'h25; mcu_data = 32'hDEADBEEF;
        tick();
        mcu_wr = 1'b0;
        chk("lat_n1_ram_wr", ram_wr, 0);
        tick();
        chk("lat_n2_ram_wr", ram_wr, 1);
        chk("lat_n2_addr", ram_addr, 6'h25);
        chk("lat_n2_data", ram_data, 32'hDEADBEEF);
        tick();
        chk("lat_n3_ram_wr", ram_wr, 0);
        chk("lat_ovf", ovf, 0);
        drain(10);

        // Full uncontended fill with an ignored restart in the middle
        exp_fill(32'h00FF00FF);
        fill_start = 1'b1; fill_data = 32'h00FF00FF;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            fill_start = 1'b0;
            if (i == 10) begin
                fill_start = 1'b1;
                fill_data  = 32'h12345678;
            end
            if (fill_busy) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        fill_start = 1'b0;
        chk("fill_busy_cycles", busy_cnt, 64);
        drain(20);
        chk("fill_busy_after", fill_busy, 0);

        // Overflow: stalled port, fifth write dropped
        ram_ready = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            if (a == 5) chk("ovf_before_drop", ovf, 0);
            mcu_wr = 1'b1; mcu_addr = AW'(a); mcu_data = 32'h1000_0000 | a;
            if (a <= 4) exp_q.push_back(ent(0, AW'(a), 32'h1000_0000 | a));
            tick();
        end
        chk("ovf_set", ovf, 1);
        mcu_addr = 6'd6; mcu_data = 32'h1000_0006; ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", ovf, 1);
        mcu_wr = 1'b0;
        tick();
        chk("ovf_cleared", ovf, 0);
        ovf_clr = 1'b0;
        ram_ready = 1'b1;
        drain(20);

        // Anti-starvation: MCU strobes every cycle alongside a fill
        mi = 0; fa = 0;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(ent(0, AW'(32 + mi), 32'hA500_0000 + mi));
                mi++;
            end
            exp_q.push_back(ent(0, AW'(fa), 32'h0F0F0F0F));
            fa++;
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ent(0, AW'(32 + mi), 32'hA500_0000 + mi));
            mi++;
        end
        for (int f = 3; f < 64; f++) exp_q.push_back(ent(f == 63, AW'(f), 32'h0F0F0F0F));
        fill_start = 1'b1; fill_data = 32'h0F0F0F0F;
        for (int i = 0; i < 15; i++) begin
            mcu_wr = 1'b1; mcu_addr = AW'(32 + i); mcu_data = 32'hA500_0000 + i;
            tick();
            fill_start = 1'b0;
        end
        mcu_wr = 1'b0;
        drain(150);
        chk("starve_no_ovf", ovf, 0);

        // Reset mid-fill at fill address 20 with two MCU writes queued
        for (int i = 0; i < 20; i++) exp_q.push_back(ent(0, AW'(i), 32'h5A5A5A5A));
        fill_start = 1'b1; fill_data = 32'h5A5A5A5A;
        for (int t = 0; t < 21; t++) begin
            tick();
            fill_start = 1'b0;
        end
        ram_ready = 1'b0;
        mcu_wr = 1'b1; mcu_addr = 6'h3A; mcu_data = 32'hBBBB0001;
        tick();
        mcu_addr = 6'h3B; mcu_data = 32'hBBBB0002;
        tick();
        mcu_wr = 1'b0;
        chk("pre_rst_last_addr", ram_addr, 19);
        chk("pre_rst_busy", fill_busy, 1);
        chk("pre_rst_queue", exp_q.size(), 0);
        rst = 1'b1;
        tick();
        chk_all_zero("midfill_rst");
        rst = 1'b0;
        ram_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_busy", fill_busy, 0);
        exp_fill(32'h33CC33CC);
        fill_start = 1'b1; fill_data = 32'h33CC33CC;
        tick();
        fill_start = 1'b0;
        drain(100);

        // Full FIFO: push accepted when a pop happens in the same cycle
        ram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ram_ready = 1'b1;
            mcu_wr = 1'b1; mcu_addr = AW'(48 + i); mcu_data = 32'hC000_0000 + i;
            exp_q.push_back(ent(0, AW'(48 + i), 32'hC000_0000 + i));
            tick();
        end
        mcu_wr = 1'b0;
        drain(20);
        chk("pushpop_ovf", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_wr_arbiter.md
# fb_wr_arbiter

Write-port arbiter and fill sequencer for the HUB75 frame-buffer dual-port RAM, in the 100 MHz write domain. It merges two requesters onto the single RAM write port: the 8080 interface's un-throttled write pulses, buffered in a small FIFO, and an internal fill engine that writes one constant word to every frame-buffer address for screen clear or solid colour. It honours a downstream `ram_ready` stall and prevents fill starvation with a bounded MCU burst.

## Interface
- `COL_NUM_LOG2`, 8, log2 of columns; address width AW = COL_NUM_LOG2+5
- `FIFO_DEPTH_LOG2`, 2, log2 of MCU FIFO depth (default 4 entries)
- `MCU_BURST`, 4, maximum consecutive MCU grants while a fill is pending
- `clk`  in  1  write-domain clock (100 MHz); sole clock
- `rst`  in  1  synchronous, active-high reset
- `mcu_wr`  in  1  single-cycle write strobe from 8080 interface
- `mcu_addr`  in  AW  write address
- `mcu_data`  in  32  write data
- `fill_start`  in  1  single-cycle fill request
- `fill_data`  in  32  fill word, sampled with `fill_start`
- `ram_ready`  in  1  downstream may accept a write issued this cycle
- `ovf_clr`  in  1  clears `ovf`
- `ram_wr`  out  1  registered RAM write enable
- `ram_addr`  out  AW  registered RAM address
- `ram_data`  out  32  registered RAM data
- `fill_busy`  out  1  fill in progress
- `fill_done`  out  1  one-cycle pulse coincident with the last fill write
- `ovf`  out  1  sticky flag: an MCU write was dropped

## Operation
- **MCU FIFO.** Depth 2^FIFO_DEPTH_LOG2, holding {addr, data}, first in first out.
  - Push on `mcu_wr`.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the write is dropped and `ovf` sets.
  - Occupancy counter is FIFO_DEPTH_LOG2+1 bits; pointers wrap modulo depth.
- **Fill FSM.**
  - IDLE: `fill_start` latches `fill_data` and zeroes `fill_addr` (AW bits) → FILL.
  - FILL: each fill grant writes `fill_addr` and then increments it. The grant at `fill_addr` = 2^AW−1 → IDLE.
  - `fill_start` in FILL is ignored, including its `fill_data`.
- **Grant, evaluated each cycle; nothing is granted if `ram_ready`=0.**
  - Priority: MCU if the FIFO is non-empty, else fill if in FILL.
  - Anti-starvation: a 3-bit counter `burst_cnt` counts consecutive MCU grants while in FILL.
  - When `burst_cnt` = MCU_BURST and both are eligible, fill wins and `burst_cnt` clears.
  - `burst_cnt` also clears on any fill grant, and whenever the FSM is IDLE.
- **Outputs.** The grant result registers into `ram_wr`/`ram_addr`/`ram_data` on the next edge.
  - Cycles without a grant give `ram_wr`=0, with `ram_addr`/`ram_data` holding their last values.
  - Downstream must accept every `ram_wr` pulse; `ram_ready` is advance notice.
- **`fill_busy`** = (state == FILL).
- **`fill_done`** registers alongside the last fill write.
- **`ovf`** sets on a drop and clears on `ovf_clr`; set wins if both occur in one cycle.
- **Reset.** All outputs 0, FIFO empty, FSM IDLE, counters 0.
  - Reset mid-fill aborts the fill; no `fill_done` is produced.
  - Buffered MCU writes are discarded.

## Timing
- MCU path: `mcu_wr` in cycle N → FIFO non-empty in N+1 → grant in N+1 if ready → `ram_wr` high in N+2.
  - Minimum latency is 2 cycles; each stalled cycle adds 1.
- Fill start: `fill_start` in N → `fill_busy`=1 from N+1 → first fill grant in N+1 → first write (`ram_addr`=0) in N+2.
- Fill end: last grant in cycle M → `fill_busy`=0 from M+1. `ram_wr`, `ram_addr`=2^AW−1 and `fill_done`=1 all appear in M+1.
- Uncontended fill: 2^AW writes on consecutive cycles.
- Throughput: at most one RAM write per cycle.
- Push and pop in the same cycle leave occupancy unchanged.

## Test plan
- **MCU latency.** Reset, `ram_ready`=1; `mcu_wr` with addr 0x0A5, data 0xDEADBEEF in cycle 10 → `ram_wr`=1 in cycle 12 only, with matching addr/data; `ovf`=0.
- **Full fill.** COL_NUM_LOG2=1 (AW=6); `fill_start` with 0x00FF00FF → 64 consecutive writes, addr 0..63, all data 0x00FF00FF.
  - `fill_done` pulses only on addr 63; `fill_busy` is high for exactly 64 cycles.
  - A second `fill_start` mid-fill with 0x12345678 has no effect.
- **Overflow.** `ram_ready`=0; 5 MCU writes (addr 1..5) → `ovf`=1 after the 5th.
  - Raise `ram_ready` → exactly 4 writes, addr 1,2,3,4 in order.
  - `ovf_clr` asserted in the same cycle as a new drop → `ovf` stays 1; a later lone `ovf_clr` → 0.
- **Anti-starvation.** A fill is active while the FIFO is kept non-empty every cycle (`mcu_wr` each cycle) → write pattern repeats 4 MCU, 1 fill.
  - Fill addresses increment by 1 per fill slot; no MCU write is lost while occupancy ≤ depth.
- **Reset mid-fill.** Assert `rst` for 1 cycle at fill addr 20 with 2 MCU entries queued → next cycle all outputs 0.
  - No further writes, no `fill_done`.
  - A new `fill_start` restarts at addr 0.
- **Full FIFO, push with pop.** FIFO full, `ram_ready` goes high in the same cycle as `mcu_wr` → write accepted, `ovf` remains 0, and 5 writes emerge in order.
